// File: rtl/crc_framer_pkg.sv
// crc_framer_pkg: shared state encoding, CRC constants and the CRC-16 byte step
package crc_framer_pkg;
    typedef enum logic [1:0] {PAYLOAD, CRC_HI, CRC_LO, DONE} state_t;
    localparam int CRC_W = 16;
    localparam logic [CRC_W-1:0] CRC_POLY_DEFAULT = 16'h1021;
    localparam logic [CRC_W-1:0] CRC_INIT_DEFAULT = 16'hFFFF;
    function automatic logic [CRC_W-1:0] crc16_step(input logic [CRC_W-1:0] crc, input logic [7:0] data, input logic [CRC_W-1:0] poly);
        logic [CRC_W-1:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) c = c[CRC_W-1] ? {c[CRC_W-2:0], 1'b0} ^ poly : {c[CRC_W-2:0], 1'b0};
        return c;
    endfunction
endpackage

// File: rtl/crc16_byte.sv
// crc16_byte: combinational CRC-16 update by one byte, MSB first, shared with the receive-side checker
module crc16_byte import crc_framer_pkg::*; #(
    parameter logic [CRC_W-1:0] POLY = CRC_POLY_DEFAULT
) (
    input  logic [CRC_W-1:0] crc_in,
    input  logic [7:0]       data_in,
    output logic [CRC_W-1:0] crc_out
);
    // fold one whole byte into the running CRC
    always_comb crc_out = crc16_step(crc_in, data_in, POLY);
endmodule

// File: rtl/crc_framer.sv
// crc_framer: passes a fixed-length payload through one register stage and appends its CRC-16 (high byte first); CRC_FRAMER_ERR_INJECT_EN adds i_err_inject to corrupt bit 0 of the next CRC low byte
module crc_framer import crc_framer_pkg::*; #(
    parameter int PAYLOAD_BYTES = 241,
    parameter int DATA_W = 8,
    parameter logic [CRC_W-1:0] CRC_POLY = CRC_POLY_DEFAULT,
    parameter logic [CRC_W-1:0] CRC_INIT = CRC_INIT_DEFAULT,
    parameter int CNT_W = $clog2(PAYLOAD_BYTES + 1)
) (
    input  logic              i_clk,
    input  logic              i_reset,
`ifdef CRC_FRAMER_ERR_INJECT_EN
    input  logic              i_err_inject,
`endif
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [DATA_W-1:0] o_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic              o_frame_done
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PAYLOAD_BYTES - 1);
    state_t state, state_n;
    logic [CNT_W-1:0] count, count_n;
    logic [CRC_W-1:0] crc, crc_n, crc_step;
    logic [DATA_W-1:0] data_n;
    logic valid_n, flip;

    crc16_byte #(.POLY(CRC_POLY)) u_crc (.crc_in(crc), .data_in(i_data), .crc_out(crc_step));

`ifdef CRC_FRAMER_ERR_INJECT_EN
    logic inject;
    // hold an inject request until the corrupted low byte has been handed off
    always_ff @(posedge i_clk)
        if (i_reset) inject <= 1'b0;
        else inject <= (state == DONE && i_ready) ? i_err_inject : inject | i_err_inject;
    assign flip = inject;
`else
    assign flip = 1'b0;
`endif

    // next-state, output register loads and handshake outputs
    always_comb begin
        state_n = state;
        count_n = count;
        crc_n = crc;
        data_n = o_data;
        valid_n = o_valid;
        o_ready = 1'b0;
        o_frame_done = 1'b0;
        case (state)
            PAYLOAD: begin
                o_ready = ~i_reset && (~o_valid || i_ready);
                if (i_valid && o_ready) begin
                    data_n = i_data;
                    valid_n = 1'b1;
                    crc_n = crc_step;
                    count_n = (count == LAST) ? '0 : count + 1'b1;
                    state_n = (count == LAST) ? CRC_HI : PAYLOAD;
                end else if (o_valid && i_ready) valid_n = 1'b0;
            end
            CRC_HI: if (~o_valid || i_ready) begin
                data_n = crc[15:8];
                valid_n = 1'b1;
                state_n = CRC_LO;
            end
            CRC_LO: if (i_ready) begin
                data_n = {crc[7:1], crc[0] ^ flip};
                state_n = DONE;
            end
            default: if (i_ready) begin
                o_frame_done = ~i_reset;
                valid_n = 1'b0;
                crc_n = CRC_INIT;
                state_n = PAYLOAD;
            end
        endcase
    end

    // state and output registers
    always_ff @(posedge i_clk)
        if (i_reset) begin
            state <= PAYLOAD;
            count <= '0;
            crc <= CRC_INIT;
            o_data <= '0;
            o_valid <= 1'b0;
        end else begin
            state <= state_n;
            count <= count_n;
            crc <= crc_n;
            o_data <= data_n;
            o_valid <= valid_n;
        end
endmodule

// File: tb/tb_crc_framer.sv
// tb_crc_framer: randomized self-checking bench for crc_framer against a bit-serial CRC reference model
module tb_crc_framer;
    typedef logic [7:0] bq_t[$];

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst9, v9, r9, or9, ov9, fd9;
    logic [7:0] d9, od9;
    logic rst241, v241, r241, or241, ov241, fd241;
    logic [7:0] d241, od241;
`ifdef CRC_FRAMER_ERR_INJECT_EN
    logic ei9;
`endif

    int tests = 0, fails = 0;
    bq_t got9, exp9, got241, exp241;
    int n9 = 0, fdc9 = 0, fdc241 = 0;
    bit mon = 1'b0, hold9 = 1'b0;
    logic [7:0] pd9;

    crc_framer #(.PAYLOAD_BYTES(9)) u9 (
        .i_clk(clk), .i_reset(rst9),
`ifdef CRC_FRAMER_ERR_INJECT_EN
        .i_err_inject(ei9),
`endif
        .i_data(d9), .i_valid(v9), .o_ready(or9),
        .o_data(od9), .o_valid(ov9), .i_ready(r9), .o_frame_done(fd9)
    );

    crc_framer #(.PAYLOAD_BYTES(241)) u241 (
        .i_clk(clk), .i_reset(rst241),
`ifdef CRC_FRAMER_ERR_INJECT_EN
        .i_err_inject(1'b0),
`endif
        .i_data(d241), .i_valid(v241), .o_ready(or241),
        .o_data(od241), .o_valid(ov241), .i_ready(r241), .o_frame_done(fd241)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] crc_model(input bq_t m);
        logic [15:0] c;
        bit fb;
        c = 16'hFFFF;
        foreach (m[i])
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ m[i][b];
                c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
            end
        return c;
    endfunction

    function automatic bq_t framed(input bq_t p, input bit flip);
        logic [15:0] c;
        bq_t f;
        c = crc_model(p);
        f = p;
        f.push_back(c[15:8]);
        f.push_back({c[7:1], c[0] ^ flip});
        return f;
    endfunction

    always @(negedge clk) if (mon) begin
        if (hold9) check("hold9", 32'({ov9, od9}), 32'({1'b1, pd9}));
        check("done9", 32'(fd9), 32'(ov9 && r9 && (n9 % 11 == 10)));
        if (fd9) fdc9++;
        if (ov9 && r9) begin
            got9.push_back(od9);
            n9++;
        end
        hold9 = ov9 && !r9;
        pd9 = od9;
        if (ov241 && r241) got241.push_back(od241);
        if (fd241) fdc241++;
    end

    task automatic run9(input int frames, input int vp, input int rp, input bit fixed, input bit inj);
        bq_t src, p;
        int cyc;
        fdc9 = 0;
        for (int f = 0; f < frames; f++) begin
            p = {};
            for (int i = 0; i < 9; i++) p.push_back(fixed ? 8'(8'h31 + i) : 8'($urandom));
            src = {src, p};
            exp9 = {exp9, framed(p, inj && f == 0)};
        end
        cyc = 0;
        while (src.size() > 0 && cyc < 5000) begin
            @(posedge clk); #1;
            v9 = ($urandom_range(99) < vp);
            d9 = v9 ? src[0] : 8'h00;
            r9 = ($urandom_range(99) < rp);
`ifdef CRC_FRAMER_ERR_INJECT_EN
            ei9 = inj && (src.size() == 9 * frames - 4);
`endif
            @(negedge clk);
            if (v9 && or9) void'(src.pop_front());
            cyc++;
        end
        check("feed9_timeout", 32'(cyc < 5000), 32'd1);
    endtask

    task automatic drain9(input int frames, input bit fixed, input bit inj);
        int cyc;
        @(posedge clk); #1;
        v9 = 1'b0;
        r9 = 1'b1;
`ifdef CRC_FRAMER_ERR_INJECT_EN
        ei9 = 1'b0;
`endif
        cyc = 0;
        while (got9.size() < exp9.size() && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("drain9_timeout", 32'(cyc < 1000), 32'd1);
        check("len9", 32'(got9.size()), 32'(exp9.size()));
        foreach (exp9[i]) if (i < got9.size()) check($sformatf("byte9[%0d]", i), 32'(got9[i]), 32'(exp9[i]));
        if (fixed)
            for (int f = 0; f < frames; f++) if (got9.size() > f * 11 + 10) begin
                check("kat_hi", 32'(got9[f * 11 + 9]), 32'h29);
                check("kat_lo", 32'(got9[f * 11 + 10]), (inj && f == 0) ? 32'hB0 : 32'hB1);
            end
        check("frames9", 32'(fdc9), 32'(frames));
        got9.delete();
        exp9.delete();
    endtask

    task automatic feed241(input bq_t q, output int gap);
        int cyc;
        gap = 0;
        cyc = 0;
        while (q.size() > 0 && cyc < 5000) begin
            @(posedge clk); #1;
            v241 = 1'b1;
            d241 = q[0];
            r241 = 1'b1;
            @(negedge clk);
            if (or241) void'(q.pop_front());
            else gap++;
            cyc++;
        end
        check("feed241_timeout", 32'(cyc < 5000), 32'd1);
        @(posedge clk); #1;
        v241 = 1'b0;
    endtask

    task automatic drain241();
        int cyc;
        cyc = 0;
        while (got241.size() < exp241.size() && cyc < 1000) begin
            @(negedge clk);
            cyc++;
        end
        check("drain241_timeout", 32'(cyc < 1000), 32'd1);
        check("len241", 32'(got241.size()), 32'(exp241.size()));
        foreach (exp241[i]) if (i < got241.size()) check($sformatf("byte241[%0d]", i), 32'(got241[i]), 32'(exp241[i]));
        got241.delete();
        exp241.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bq_t q, p;
        int gap, bad;
        rst9 = 1'b1; rst241 = 1'b1;
        v9 = 1'b0; r9 = 1'b0; d9 = 8'h00;
        v241 = 1'b0; r241 = 1'b0; d241 = 8'h00;
`ifdef CRC_FRAMER_ERR_INJECT_EN
        ei9 = 1'b0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_ready9", 32'(or9), 32'd0);
        check("rst_done9", 32'(fd9), 32'd0);
        check("rst_ready241", 32'(or241), 32'd0);
        @(posedge clk); #1;
        rst9 = 1'b0; rst241 = 1'b0;
        @(negedge clk);
        check("rst_valid9", 32'(ov9), 32'd0);
        check("rst_data9", 32'(od9), 32'd0);
        check("idle_ready9", 32'(or9), 32'd1);
        check("rst_valid241", 32'(ov241), 32'd0);
        mon = 1'b1;

        run9(1, 100, 100, 1'b1, 1'b0);
        drain9(1, 1'b1, 1'b0);

        run9(20, 70, 50, 1'b0, 1'b0);
        drain9(20, 1'b0, 1'b0);

        run9(1, 100, 100, 1'b1, 1'b0);
        @(posedge clk); #1;
        v9 = 1'b0;
        @(posedge clk); #1;
        r9 = 1'b0;
        bad = 0;
        repeat (500) begin
            @(negedge clk);
            if (od9 !== 8'h29 || ov9 !== 1'b1 || or9 !== 1'b0) bad++;
        end
        check("stall_hi", 32'(od9), 32'h29);
        check("stall_ready", 32'(or9), 32'd0);
        check("stall_bad_cycles", 32'(bad), 32'd0);
        drain9(1, 1'b1, 1'b0);

`ifdef CRC_FRAMER_ERR_INJECT_EN
        run9(2, 100, 100, 1'b1, 1'b1);
        drain9(2, 1'b1, 1'b1);
`endif

        q = {};
        p = {};
        for (int i = 0; i < 241; i++) p.push_back(8'h00);
        q = {p, p};
        exp241 = {framed(p, 1'b0), framed(p, 1'b0)};
        fdc241 = 0;
        feed241(q, gap);
        check("gap241", 32'(gap), 32'd3);
        drain241();
        check("frames241", 32'(fdc241), 32'd2);

        q = {};
        for (int i = 0; i < 101; i++) q.push_back(8'($urandom));
        feed241(q, gap);
        rst241 = 1'b1;
        @(negedge clk);
        check("midrst_ready", 32'(or241), 32'd0);
        @(posedge clk); #1;
        rst241 = 1'b0;
        @(negedge clk);
        check("midrst_valid", 32'(ov241), 32'd0);
        got241.delete();
        p = {};
        for (int i = 0; i < 241; i++) p.push_back(8'($urandom));
        exp241 = framed(p, 1'b0);
        feed241(p, gap);
        drain241();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
